rf_access_arbiter: RTL and testbench

Sequencer that shares the single 32x32 register file (REGISTER_FILE_32x32) between two requesters, for example the ALU writeback path and the load/store path. The block accepts one read or write command per requester through a REQ/ACK handshake and arbitrates between the two. It drives the register file's READ/WRITE/address/data pins for exactly one operation at a time, and returns captured read data with the ACK. It sits between the requesters and the register file; the requesters never drive the register file directly.

---
 rtl/rf_access_arbiter_pkg.sv | 26 ++
 rtl/rf_access_arbiter_if.sv | 38 +++
 rtl/rf_access_arbiter_pick.sv | 43 ++++
 rtl/rf_access_arbiter.sv | 126 ++++++++++++
 tb/tb_rf_access_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_access_arbiter_pkg.sv
// Shared widths and command types for the register-file access arbiter.
// Widths mirror prj_definition.v so the arbiter matches the other register file blocks.
package rf_access_arbiter_pkg;

  localparam int DATA_WIDTH           = 32;
  localparam int DATA_INDEX_LIMIT     = DATA_WIDTH - 1;
  localparam int REG_ADDR_INDEX_LIMIT = 4;
  localparam int REG_ADDR_WIDTH       = REG_ADDR_INDEX_LIMIT + 1;

  typedef logic [DATA_INDEX_LIMIT:0]     rf_data_t;
  typedef logic [REG_ADDR_INDEX_LIMIT:0] rf_addr_t;

  // One latched requester command: direction, both read ports, write port.
  typedef struct packed {
    logic     we;
    rf_addr_t addr_r1;
    rf_addr_t addr_r2;
    rf_addr_t addr_w;
    rf_data_t data_w;
  } rf_cmd_t;

  function automatic rf_cmd_t select_cmd(input logic sel, input rf_cmd_t c0, input rf_cmd_t c1);
    return sel ? c1 : c0;
  endfunction

endpackage

// File: rtl/rf_access_arbiter_if.sv
// Requester-side handshake bundle of the register-file access arbiter.
// master = the two requesters, slave = the arbiter.
interface rf_access_arbiter_if;
  import rf_access_arbiter_pkg::*;

  logic     req0;
  logic     req1;
  logic     we0;
  logic     we1;
  rf_addr_t addr_r1_0;
  rf_addr_t addr_r1_1;
  rf_addr_t addr_r2_0;
  rf_addr_t addr_r2_1;
  rf_addr_t addr_w_0;
  rf_addr_t addr_w_1;
  rf_data_t data_w_0;
  rf_data_t data_w_1;
  logic     ack0;
  logic     ack1;
  rf_data_t rd1;
  rf_data_t rd2;
  logic     busy;

  modport master (
    output req0, req1, we0, we1,
    output addr_r1_0, addr_r1_1, addr_r2_0, addr_r2_1, addr_w_0, addr_w_1,
    output data_w_0, data_w_1,
    input  ack0, ack1, rd1, rd2, busy
  );

  modport slave (
    input  req0, req1, we0, we1,
    input  addr_r1_0, addr_r1_1, addr_r2_0, addr_r2_1, addr_w_0, addr_w_1,
    input  data_w_0, data_w_1,
    output ack0, ack1, rd1, rd2, busy
  );

endinterface

// File: rtl/rf_access_arbiter_pick.sv
// rf_arb_pick: two-way winner selection. With RF_ARB_ROUND_ROBIN_EN defined it keeps
// the LAST flop (1 = requester 1 granted last); otherwise requester 0 has fixed priority.
module rf_arb_pick (
`ifdef RF_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic rst,
  input  logic grant,
`endif
  input  logic req0,
  input  logic req1,
  output logic winner
);

`ifdef RF_ARB_ROUND_ROBIN_EN
  logic last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (grant) begin
      last <= winner;
    end
  end

  // Under contention the requester not granted last wins.
  always_comb begin
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = 1'b1;
    end
  end
`else
  always_comb begin
    winner = 1'b0;
    if (req1 && !req0) begin
      winner = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/rf_access_arbiter.sv
// Shares one 32x32 register file between two REQ/ACK requesters, one operation at a time.
// Optional macro RF_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
module rf_access_arbiter
  import rf_access_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  rf_access_arbiter_if.slave   req_if,
  output logic                 rf_read,
  output logic                 rf_write,
  output rf_addr_t             rf_addr_r1,
  output rf_addr_t             rf_addr_r2,
  output rf_addr_t             rf_addr_w,
  output rf_data_t             rf_data_w,
  input  rf_data_t             rf_data_r1,
  input  rf_data_t             rf_data_r2
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  arb_state_t state;
  arb_state_t state_nxt;

  logic    any_req;
  logic    accept;
  logic    winner;
  rf_cmd_t cmd0;
  rf_cmd_t cmd1;
  rf_cmd_t cmd;
  logic    cmd_id;
  rf_data_t rd1;
  rf_data_t rd2;

  assign cmd0 = '{we: req_if.we0, addr_r1: req_if.addr_r1_0, addr_r2: req_if.addr_r2_0,
                  addr_w: req_if.addr_w_0, data_w: req_if.data_w_0};
  assign cmd1 = '{we: req_if.we1, addr_r1: req_if.addr_r1_1, addr_r2: req_if.addr_r2_1,
                  addr_w: req_if.addr_w_1, data_w: req_if.data_w_1};

  assign any_req = req_if.req0 | req_if.req1;
  assign accept  = (state == ST_IDLE) && any_req;

  rf_arb_pick u_pick (
`ifdef RF_ARB_ROUND_ROBIN_EN
    .clk    (clk),
    .rst    (rst),
    .grant  (accept),
`endif
    .req0   (req_if.req0),
    .req1   (req_if.req1),
    .winner (winner)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = cmd.we ? ST_RESP : ST_WAIT;
      ST_WAIT:  state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Command registers: loaded only on acceptance, so requesters may drop REQ afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd    <= '0;
      cmd_id <= 1'b0;
    end else if (accept) begin
      cmd    <= select_cmd(winner, cmd0, cmd1);
      cmd_id <= winner;
    end
  end

  // Read data is taken on the edge leaving WAIT; writes leave RD1/RD2 untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd1 <= '0;
      rd2 <= '0;
    end else if (state == ST_WAIT) begin
      rd1 <= rf_data_r1;
      rd2 <= rf_data_r2;
    end
  end

  always_comb begin
    rf_read     = 1'b0;
    rf_write    = 1'b0;
    req_if.ack0 = 1'b0;
    req_if.ack1 = 1'b0;
    case (state)
      ST_ISSUE: begin
        rf_write = cmd.we;
        rf_read  = ~cmd.we;
      end
      ST_WAIT:  rf_read = 1'b1;
      ST_RESP: begin
        req_if.ack0 = ~cmd_id;
        req_if.ack1 = cmd_id;
      end
      default: ;
    endcase
  end

  assign req_if.busy = (state != ST_IDLE);
  assign req_if.rd1  = rd1;
  assign req_if.rd2  = rd2;
  assign rf_addr_r1  = cmd.addr_r1;
  assign rf_addr_r2  = cmd.addr_r2;
  assign rf_addr_w   = cmd.addr_w;
  assign rf_data_w   = cmd.data_w;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Bench for rf_access_arbiter: register file model, transaction-timeline reference model,
// per-cycle compare, and directed scenarios with literal expectations.
module tb_rf_access_arbiter;
  import rf_access_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_access_arbiter_if ifc();

  logic     rf_read, rf_write;
  rf_addr_t rf_addr_r1, rf_addr_r2, rf_addr_w;
  rf_data_t rf_data_w;
  rf_data_t rf_data_r1 = '0;
  rf_data_t rf_data_r2 = '0;

  rf_access_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_if     (ifc),
    .rf_read    (rf_read),
    .rf_write   (rf_write),
    .rf_addr_r1 (rf_addr_r1),
    .rf_addr_r2 (rf_addr_r2),
    .rf_addr_w  (rf_addr_w),
    .rf_data_w  (rf_data_w),
    .rf_data_r1 (rf_data_r1),
    .rf_data_r2 (rf_data_r2)
  );

  // Register file: synchronous write, registered read.
  rf_data_t mem [32] = '{default: '0};
  always @(posedge clk) begin
    if (rf_write) mem[rf_addr_w] <= rf_data_w;
    if (rf_read) begin
      rf_data_r1 <= mem[rf_addr_r1];
      rf_data_r2 <= mem[rf_addr_r2];
    end
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: m_k counts cycles since acceptance (0 = no command in flight).
  int       m_k = 0;
  logic     m_we = 1'b0, m_id = 1'b0, m_last = 1'b1;
  rf_addr_t m_a1 = '0, m_a2 = '0, m_aw = '0;
  rf_data_t m_dw = '0, m_rd1 = '0, m_rd2 = '0;
  rf_data_t shadow [32] = '{default: '0};

  function automatic logic model_winner(input logic r0, input logic r1, input logic last);
`ifdef RF_ARB_ROUND_ROBIN_EN
    if (r0 && r1) return !last;
`else
    if (r0 && r1) return 1'b0;
`endif
    return r1 && !r0;
  endfunction

  logic mw;
  assign mw = model_winner(ifc.req0, ifc.req1, m_last);

  always @(posedge clk) begin
    if (rst) begin
      if (m_k == 1 && m_we) shadow[m_aw] <= m_dw;
      m_k <= 0; m_last <= 1'b1; m_rd1 <= '0; m_rd2 <= '0;
    end else if (m_k == 0) begin
      if (ifc.req0 || ifc.req1) begin
        m_k    <= 1;
        m_id   <= mw;
        m_last <= mw;
        m_we   <= mw ? ifc.we1 : ifc.we0;
        m_a1   <= mw ? ifc.addr_r1_1 : ifc.addr_r1_0;
        m_a2   <= mw ? ifc.addr_r2_1 : ifc.addr_r2_0;
        m_aw   <= mw ? ifc.addr_w_1 : ifc.addr_w_0;
        m_dw   <= mw ? ifc.data_w_1 : ifc.data_w_0;
      end
    end else if (m_we) begin
      if (m_k == 1) shadow[m_aw] <= m_dw;
      m_k <= (m_k == 1) ? 2 : 0;
    end else begin
      if (m_k == 2) begin
        m_rd1 <= shadow[m_a1];
        m_rd2 <= shadow[m_a2];
      end
      m_k <= (m_k == 3) ? 0 : m_k + 1;
    end
  end

  int ack0_cnt = 0, ack1_cnt = 0, wr_cnt = 0, overlap = 0;
  logic [4:0] last_waddr = '0;
  int ack_log[$];

  // Per-cycle compare against the model, plus event monitors.
  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("busy", ifc.busy, m_k != 0);
      chk("rf_write", rf_write, m_k == 1 && m_we);
      chk("rf_read", rf_read, !m_we && (m_k == 1 || m_k == 2));
      chk("ack0", ifc.ack0, (m_k == (m_we ? 2 : 3)) && !m_id);
      chk("ack1", ifc.ack1, (m_k == (m_we ? 2 : 3)) && m_id);
      chk("rd1", ifc.rd1, m_rd1);
      chk("rd2", ifc.rd2, m_rd2);
      if (m_k == 1 && m_we) begin
        chk("rf_addr_w", rf_addr_w, m_aw);
        chk("rf_data_w", rf_data_w, m_dw);
      end
      if (!m_we && (m_k == 1 || m_k == 2)) begin
        chk("rf_addr_r1", rf_addr_r1, m_a1);
        chk("rf_addr_r2", rf_addr_r2, m_a2);
      end
    end
    if (ifc.ack0 === 1'b1) begin ack0_cnt++; ack_log.push_back(0); end
    if (ifc.ack1 === 1'b1) begin ack1_cnt++; ack_log.push_back(1); end
    if (rf_write === 1'b1) begin wr_cnt++; last_waddr = rf_addr_w; end
    if (rf_read === 1'b1 && rf_write === 1'b1) overlap++;
  end

  task automatic set_fields(input logic id, input logic r, input logic we, input rf_addr_t a1,
                            input rf_addr_t a2, input rf_addr_t aw, input rf_data_t dw);
    if (!id) begin
      ifc.req0 = r; ifc.we0 = we; ifc.addr_r1_0 = a1; ifc.addr_r2_0 = a2;
      ifc.addr_w_0 = aw; ifc.data_w_0 = dw;
    end else begin
      ifc.req1 = r; ifc.we1 = we; ifc.addr_r1_1 = a1; ifc.addr_r2_1 = a2;
      ifc.addr_w_1 = aw; ifc.data_w_1 = dw;
    end
  endtask

  task automatic wait_ack(input logic id, output int at, output rf_data_t r1, output rf_data_t r2);
    at = -1; r1 = '0; r2 = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ((id ? ifc.ack1 : ifc.ack0) === 1'b1) begin
        at = cyc; r1 = ifc.rd1; r2 = ifc.rd2;
        break;
      end
    end
    if (at < 0) begin
      checks++; failures++;
      $display("FAIL ack_timeout: requester %0d got no ACK within 30 cycles", id);
    end
  endtask

  task automatic one_cmd(input logic id, input logic we, input rf_addr_t a1, input rf_addr_t a2,
                         input rf_addr_t aw, input rf_data_t dw,
                         output int lat, output rf_data_t r1, output rf_data_t r2);
    int t0, at;
    @(posedge clk); #2;
    set_fields(id, 1'b1, we, a1, a2, aw, dw);
    t0 = cyc;
    wait_ack(id, at, r1, r2);
    lat = at - t0;
    @(posedge clk); #2;
    set_fields(id, 1'b0, we, a1, a2, aw, dw);
  endtask

  // Writes n commands with REQ held across each ACK; new fields appear on the edge ending RESP.
  task automatic held_seq(input logic id, input int n, input rf_addr_t base,
                          output int first_at, output int last_at);
    int at;
    rf_data_t r1, r2;
    first_at = -1; last_at = -1;
    @(posedge clk); #2;
    set_fields(id, 1'b1, 1'b1, '0, '0, base, 32'hC000_0000 | (32'(id) << 8) | 32'(base));
    for (int i = 0; i < n; i++) begin
      wait_ack(id, at, r1, r2);
      if (i == 0) first_at = at;
      last_at = at;
      @(posedge clk); #2;
      if (i < n - 1)
        set_fields(id, 1'b1, 1'b1, '0, '0, base + rf_addr_t'(i + 1),
                   32'hC000_0000 | (32'(id) << 8) | (32'(base) + 32'(i + 1)));
      else
        set_fields(id, 1'b0, 1'b1, '0, '0, '0, '0);
    end
  endtask

  int lat, f0, l0, f1, l1, a0c, a1c, wc0;
  rf_data_t r1, r2;
  int exp_order [4];

  initial begin
`ifdef RF_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 1, 1};
`endif
    set_fields(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    set_fields(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_ack0", ifc.ack0, 1'b0);
    chk("rst_ack1", ifc.ack1, 1'b0);
    chk("rst_rf_read", rf_read, 1'b0);
    chk("rst_rf_write", rf_write, 1'b0);
    chk("rst_addr_w", rf_addr_w, 5'd0);
    chk("rst_addr_r1", rf_addr_r1, 5'd0);
    chk("rst_data_w", rf_data_w, 32'h0);
    chk("rst_rd1", ifc.rd1, 32'h0);

    wc0 = wr_cnt;
    one_cmd(1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h0000_00A5, lat, r1, r2);
    chk("wr_latency", lat, 2);
    chk("wr_pulses", wr_cnt - wc0, 1);
    chk("wr_addr", last_waddr, 5'd3);
    chk("wr_no_ack1", ack1_cnt, 0);
    one_cmd(1'b0, 1'b1, 5'd0, 5'd0, 5'd4, 32'h0000_005A, lat, r1, r2);
    one_cmd(1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 32'h0, lat, r1, r2);
    chk("rd_latency", lat, 3);
    chk("rd_rd1", r1, 32'h0000_00A5);
    chk("rd_rd2", r2, 32'h0000_005A);
    chk("rd_ack1_once", ack1_cnt, 1);

    ack_log.delete();
    fork
      held_seq(1'b0, 2, 5'd10, f0, l0);
      held_seq(1'b1, 2, 5'd12, f1, l1);
    join
    chk("contend_count", ack_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < ack_log.size()) chk("contend_order", ack_log[i], exp_order[i]);

    a0c = ack0_cnt;
    @(posedge clk); #2;
    set_fields(1'b0, 1'b1, 1'b0, 5'd10, 5'd13, '0, '0);
    @(posedge clk); #2;
    set_fields(1'b0, 1'b0, 1'b0, 5'd10, 5'd13, '0, '0);
    repeat (8) @(negedge clk);
    chk("drop_ack0_once", ack0_cnt - a0c, 1);
    chk("drop_rd1", ifc.rd1, 32'hC000_000A);
    chk("drop_rd2", ifc.rd2, 32'hC000_010D);

    a1c = ack1_cnt;
    @(posedge clk); #2;
    set_fields(1'b1, 1'b1, 1'b0, 5'd3, 5'd4, '0, '0);
    @(posedge clk);
    @(posedge clk); #2;
    chk("wait_busy", ifc.busy, 1'b1);
    chk("wait_rf_read", rf_read, 1'b1);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    set_fields(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    chk("mrst_busy", ifc.busy, 1'b0);
    chk("mrst_rf_read", rf_read, 1'b0);
    chk("mrst_rd1", ifc.rd1, 32'h0);
    chk("mrst_rd2", ifc.rd2, 32'h0);
    repeat (6) @(negedge clk);
    chk("mrst_no_ack1", ack1_cnt - a1c, 0);

    held_seq(1'b0, 3, 5'd20, f0, l0);
    chk("b2b_span", l0 - f0, 6);
    chk("b2b_no_overlap", overlap, 0);
    one_cmd(1'b1, 1'b0, 5'd20, 5'd22, 5'd0, 32'h0, lat, r1, r2);
    chk("b2b_rd1", r1, 32'hC000_0014);
    chk("b2b_rd2", r2, 32'hC000_0016);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
